// File: rtl/reproductor_melodia_pkg.sv
// Shared definitions for the melody player: FSM encoding, table markers and a
// helper that sizes the duration counter.
package reproductor_melodia_pkg;

    typedef enum logic [2:0] {
        StReposo,
        StCarga,
        StSonando,
        StPausa,
        StFin
    } estado_t;

    // A zero half-period in the note table marks the end of the melody.
    localparam logic [15:0] NOTA_MUDA = 16'd0;
    // Last addressable note; playback never wraps past it.
    localparam logic [4:0]  IDX_MAX   = 5'd31;

    // Width needed to count 0..max(a,b)-1, never less than one bit.
    function automatic int unsigned ancho_contador(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/reproductor_melodia_if.sv
// Control and note-table signals of the melody player. The player is the
// master: it drives the table index and the audio/status outputs.
interface reproductor_melodia_if;

    logic        start;
    logic        stop;
    logic [15:0] nota;
    logic [4:0]  i;
    logic        buzzer;
    logic        ocupado;
    logic        fin;

    modport master (
        input  start,
        input  stop,
        input  nota,
        output i,
        output buzzer,
        output ocupado,
        output fin
    );

    modport slave (
        output start,
        output stop,
        output nota,
        input  i,
        input  buzzer,
        input  ocupado,
        input  fin
    );

endinterface

// File: rtl/reproductor_melodia_generador_tono.sv
// Square-wave generator: toggles the output every i_nota_q cycles while
// enabled; counter and output are held at zero while disabled.
module reproductor_melodia_generador_tono (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_nota_q,
    input  logic        i_enable,
    output logic        o_buzzer
);

    logic [15:0] r_cnt;
    logic        r_buzzer;
    logic        w_wrap;

    // i_nota_q is never zero while enabled, so the decrement cannot wrap.
    assign w_wrap = (r_cnt == (i_nota_q - 16'd1));

    // Half-period counter and toggle flop, both cleared while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n || !i_enable) begin
            r_cnt    <= '0;
            r_buzzer <= 1'b0;
        end else if (w_wrap) begin
            r_cnt    <= '0;
            r_buzzer <= ~r_buzzer;
        end else begin
            r_cnt    <= r_cnt + 16'd1;
        end
    end

    assign o_buzzer = r_buzzer;

endmodule

// File: rtl/reproductor_melodia.sv
// Melody player: walks the note table, sounds each note for DUR_NOTA cycles,
// then stays silent for DUR_SILENCIO cycles, until the end marker or index 31.
module reproductor_melodia
    import reproductor_melodia_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 12000000,
    parameter int unsigned DUR_NOTA        = CLOCK_FREQUENCY / 4,
    parameter int unsigned DUR_SILENCIO    = CLOCK_FREQUENCY / 20,
    parameter bit          REPETIR         = 1'b0
) (
    input logic                   clk,
    input logic                   rst_n,
    reproductor_melodia_if.master melodia
);

    localparam int unsigned CntW = ancho_contador(DUR_NOTA, DUR_SILENCIO);
    localparam logic [CntW-1:0] UltNota     = CntW'(DUR_NOTA - 1);
    localparam logic [CntW-1:0] UltSilencio = CntW'(DUR_SILENCIO - 1);

    estado_t         r_state;
    estado_t         w_state_d;
    logic [4:0]      r_i;
    logic [4:0]      w_i_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic [15:0]     r_nota;
    logic            w_tono_en;
    logic            w_buzzer;

    // State, index and duration counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StReposo;
            r_i     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_i     <= w_i_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Half-period of the current note, captured during the load cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nota <= '0;
        end else if (r_state == StCarga) begin
            r_nota <= melodia.nota;
        end
    end

    // Next-state logic; the duration counter restarts on every state change.
    always_comb begin
        w_state_d = r_state;
        w_i_d     = r_i;
        w_cnt_d   = '0;
        unique case (r_state)
            StReposo: begin
                w_i_d = '0;
                if (melodia.start) begin
                    w_state_d = StCarga;
                end
            end
            StCarga: begin
                w_state_d = (melodia.nota == NOTA_MUDA) ? StFin : StSonando;
            end
            StSonando: begin
                if (r_cnt == UltNota) begin
                    w_state_d = StPausa;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StPausa: begin
                if (r_cnt == UltSilencio) begin
                    if (r_i == IDX_MAX) begin
                        w_state_d = StFin;
                    end else begin
                        w_i_d     = r_i + 5'd1;
                        w_state_d = StCarga;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StFin: begin
                w_i_d     = '0;
                w_state_d = REPETIR ? StCarga : StReposo;
            end
            default: begin
                w_i_d     = '0;
                w_state_d = StReposo;
            end
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (melodia.stop) begin
            w_state_d = StReposo;
            w_i_d     = '0;
            w_cnt_d   = '0;
        end
    end

    // Tone runs only while staying in SONANDO: it starts from zero on entry and
    // the buzzer is already low in the first cycle after leaving.
    assign w_tono_en = (r_state == StSonando) && (w_state_d == StSonando);

    reproductor_melodia_generador_tono u_tono (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_nota_q (r_nota),
        .i_enable (w_tono_en),
        .o_buzzer (w_buzzer)
    );

    assign melodia.i       = r_i;
    assign melodia.buzzer  = w_buzzer;
    assign melodia.ocupado = (r_state != StReposo);
    assign melodia.fin     = (r_state == StFin);

endmodule

// File: tb/tb_reproductor_melodia.sv
// Directed bench for the melody player: three instances with stub note tables
// (stop mode, repeat mode, and a table with no end marker to reach index 31).
module tb_reproductor_melodia;

    localparam int unsigned DurN = 100;
    localparam int unsigned DurS = 10;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   fin0_cnt;
    int   finw_cnt;

    reproductor_melodia_if bus0 ();
    reproductor_melodia_if busr ();
    reproductor_melodia_if busw ();

    reproductor_melodia #(.DUR_NOTA(DurN), .DUR_SILENCIO(DurS), .REPETIR(1'b0)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .melodia (bus0)
    );

    reproductor_melodia #(.DUR_NOTA(DurN), .DUR_SILENCIO(DurS), .REPETIR(1'b1)) dutr (
        .clk     (clk),
        .rst_n   (rst_n),
        .melodia (busr)
    );

    reproductor_melodia #(.DUR_NOTA(DurN), .DUR_SILENCIO(DurS), .REPETIR(1'b0)) dutw (
        .clk     (clk),
        .rst_n   (rst_n),
        .melodia (busw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub tables: 3, 5, then end marker; third table never ends (1, then 2s).
    always_comb begin
        case (bus0.i)
            5'd0:    bus0.nota = 16'd3;
            5'd1:    bus0.nota = 16'd5;
            default: bus0.nota = 16'd0;
        endcase
        case (busr.i)
            5'd0:    busr.nota = 16'd3;
            5'd1:    busr.nota = 16'd5;
            default: busr.nota = 16'd0;
        endcase
        busw.nota = (busw.i == 5'd0) ? 16'd1 : 16'd2;
    end

    always @(negedge clk) begin
        if (bus0.fin) fin0_cnt <= fin0_cnt + 1;
        if (busw.fin) finw_cnt <= finw_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Follows one full note plus silence on dut0, starting from its load cycle.
    task automatic play0(input int half, input logic [4:0] idx);
        for (int k = 0; k < int'(DurN); k++) begin
            tick();
            chk("note_buzzer", {31'd0, bus0.buzzer}, (k / half) % 2);
            chk("note_i", {27'd0, bus0.i}, {27'd0, idx});
        end
        for (int p = 0; p < int'(DurS); p++) begin
            tick();
            chk("pause_buzzer", {31'd0, bus0.buzzer}, 32'd0);
            chk("pause_ocupado", {31'd0, bus0.ocupado}, 32'd1);
            chk("pause_i", {27'd0, bus0.i}, {27'd0, idx});
        end
    endtask

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       exp_ocupado;
        logic [4:0] exp_i;
        logic       exp_buzzer;
        logic       exp_fin;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // {start, stop} applied before an edge; outputs expected after it
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};

        n_checks = 0;
        n_errors = 0;
        fin0_cnt = 0;
        finw_cnt = 0;
        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.stop = 1'b0;
        busr.start = 1'b0; busr.stop = 1'b0;
        busw.start = 1'b0; busw.stop = 1'b0;

        // Reset held for three cycles, then idle without start
        repeat (3) tick();
        chk("rst_i", {27'd0, bus0.i}, 32'd0);
        chk("rst_buzzer", {31'd0, bus0.buzzer}, 32'd0);
        chk("rst_ocupado", {31'd0, bus0.ocupado}, 32'd0);
        chk("rst_fin", {31'd0, bus0.fin}, 32'd0);
        chk("rst_ocupado_r", {31'd0, busr.ocupado}, 32'd0);
        chk("rst_ocupado_w", {31'd0, busw.ocupado}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_ocupado", {31'd0, bus0.ocupado}, 32'd0);
        chk("idle_i", {27'd0, bus0.i}, 32'd0);

        // Start/stop priority, second start mid-note, first toggles, abort
        for (int v = 0; v < 13; v++) begin
            bus0.start = vecs[v].start;
            bus0.stop  = vecs[v].stop;
            tick();
            chk($sformatf("vec%0d_ocupado", v), {31'd0, bus0.ocupado}, {31'd0, vecs[v].exp_ocupado});
            chk($sformatf("vec%0d_i", v), {27'd0, bus0.i}, {27'd0, vecs[v].exp_i});
            chk($sformatf("vec%0d_buzzer", v), {31'd0, bus0.buzzer}, {31'd0, vecs[v].exp_buzzer});
            chk($sformatf("vec%0d_fin", v), {31'd0, bus0.fin}, {31'd0, vecs[v].exp_fin});
        end
        bus0.start = 1'b0;
        bus0.stop  = 1'b0;

        // Full melody: note 0, note 1, end marker, single fin pulse
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        chk("start_ocupado", {31'd0, bus0.ocupado}, 32'd1);
        play0(3, 5'd0);
        tick();
        chk("load1_i", {27'd0, bus0.i}, 32'd1);
        play0(5, 5'd1);
        tick();
        chk("load2_i", {27'd0, bus0.i}, 32'd2);
        chk("load2_fin", {31'd0, bus0.fin}, 32'd0);
        tick();
        chk("end_fin", {31'd0, bus0.fin}, 32'd1);
        chk("end_buzzer", {31'd0, bus0.buzzer}, 32'd0);
        tick();
        chk("after_fin", {31'd0, bus0.fin}, 32'd0);
        chk("after_ocupado", {31'd0, bus0.ocupado}, 32'd0);
        chk("after_i", {27'd0, bus0.i}, 32'd0);
        chk("fin_pulses", fin0_cnt, 32'd1);

        // Stop 40 cycles into note 0 while buzzer is high
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (41) tick();
        chk("s40_buzzer", {31'd0, bus0.buzzer}, 32'd1);
        bus0.stop = 1'b1;
        tick();
        bus0.stop = 1'b0;
        chk("stop_buzzer", {31'd0, bus0.buzzer}, 32'd0);
        chk("stop_ocupado", {31'd0, bus0.ocupado}, 32'd0);
        chk("stop_i", {27'd0, bus0.i}, 32'd0);
        repeat (3) tick();
        chk("stop_idle", {31'd0, bus0.ocupado}, 32'd0);
        chk("stop_no_fin", fin0_cnt, 32'd1);

        // Stop during note 1 must return the index to 0
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        play0(3, 5'd0);
        repeat (6) tick();
        chk("n1_i", {27'd0, bus0.i}, 32'd1);
        bus0.stop = 1'b1;
        tick();
        bus0.stop = 1'b0;
        chk("stop1_i", {27'd0, bus0.i}, 32'd0);
        chk("stop1_ocupado", {31'd0, bus0.ocupado}, 32'd0);

        // Repeat mode: after the end marker, note 0 replays
        busr.start = 1'b1;
        tick();
        busr.start = 1'b0;
        chk("rep_ocupado", {31'd0, busr.ocupado}, 32'd1);
        repeat (DurN + DurS) tick();
        tick();
        chk("rep_load1_i", {27'd0, busr.i}, 32'd1);
        repeat (DurN + DurS) tick();
        tick();
        chk("rep_load2_i", {27'd0, busr.i}, 32'd2);
        tick();
        chk("rep_fin", {31'd0, busr.fin}, 32'd1);
        tick();
        chk("rep_reload_i", {27'd0, busr.i}, 32'd0);
        chk("rep_reload_ocupado", {31'd0, busr.ocupado}, 32'd1);
        chk("rep_reload_fin", {31'd0, busr.fin}, 32'd0);
        tick();
        chk("rep_s0_buzzer", {31'd0, busr.buzzer}, 32'd0);
        repeat (3) tick();
        chk("rep_s3_buzzer", {31'd0, busr.buzzer}, 32'd1);
        busr.stop = 1'b1;
        tick();
        busr.stop = 1'b0;
        chk("rep_stop", {31'd0, busr.ocupado}, 32'd0);

        // No end marker: half-period 1 toggles every cycle, playback stops at 31
        busw.start = 1'b1;
        tick();
        busw.start = 1'b0;
        tick();
        chk("w_s0_buzzer", {31'd0, busw.buzzer}, 32'd0);
        tick();
        chk("w_s1_buzzer", {31'd0, busw.buzzer}, 32'd1);
        tick();
        chk("w_s2_buzzer", {31'd0, busw.buzzer}, 32'd0);
        repeat (DurN + DurS - 3) tick();
        for (int n = 1; n < 32; n++) begin
            tick();
            chk("w_load_i", {27'd0, busw.i}, n);
            repeat (DurN + DurS) tick();
        end
        tick();
        chk("w_fin", {31'd0, busw.fin}, 32'd1);
        chk("w_fin_i", {27'd0, busw.i}, 32'd31);
        tick();
        chk("w_end_i", {27'd0, busw.i}, 32'd0);
        chk("w_end_ocupado", {31'd0, busw.ocupado}, 32'd0);
        chk("w_fin_pulses", finw_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
